cache: RTL and testbench
========================

CACHE -- requirements
Module: cache

Interface
REQ-001 The module SHALL have parameter LINE_IX_BITWIDTH, default 1, giving log2 of the number of cache lines.
REQ-002 The module SHALL have parameter RAM_DEPTH_BITWIDTH, default 10, giving the width of br_addr.
REQ-003 The module SHALL have parameter RAM_ADDRESSING_MODE, default 3, where br_addr = byte address >> RAM_ADDRESSING_MODE (0 byte, 1 half word, 2 word, 3 64-bit unit).
REQ-004 The module SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  synchronous reset, active-high, sampled on the rising clk edge; the name is the codebase's reset name, the polarity is fixed as stated.
REQ-007 enable  in  1  a request is present.
REQ-008 address  in  32  byte address; bits [1:0] are ignored (word-aligned).
REQ-009 data_in  in  32  write data, bytes already placed in lanes.
REQ-010 write_enable  in  4  byte-lane write strobes; 0 means read.
REQ-011 data_out  out  32  addressed word.
REQ-012 data_out_ready  out  1  data_out is valid, or the write has been accepted.
REQ-013 busy  out  1  a miss is being serviced.
REQ-014 br_cmd  out  1  burst command: 0 read, 1 write.
REQ-015 br_cmd_en  out  1  br_cmd and br_addr are valid this cycle.
REQ-016 br_addr  out  RAM_DEPTH_BITWIDTH  burst start address.
REQ-017 br_wr_data  out  64  write beat data.
REQ-018 br_data_mask  out  8  constant 0 (write all bytes).
REQ-019 br_rd_data  in  64  read beat data.
REQ-020 br_rd_data_valid  in  1  br_rd_data is valid.

Function
REQ-021 The cache SHALL be direct-mapped and write-back, with 2^LINE_IX_BITWIDTH lines of 32 bytes (8 words); each line holds a valid bit, a dirty bit and tag = address[31:5+LINE_IX_BITWIDTH].
REQ-022 Line index SHALL be address[5+LINE_IX_BITWIDTH-1:5]; word-in-line SHALL be address[4:2].
REQ-023 One line SHALL equal one burst of 4 × 64-bit beats; beat k carries line bytes 8k..8k+7, with the lower word in bits [31:0].
REQ-024 Hit = enable && valid && tag match; in IDLE on a hit, data_out SHALL be combinational from the line and data_out_ready SHALL be 1 in the same cycle, with busy=0.
REQ-025 On a hit with write_enable≠0, the enabled bytes SHALL update on the next edge and the line SHALL be marked dirty; data_out in that cycle shows pre-write content.
REQ-026 With enable=0, data_out_ready SHALL be 0 and no state SHALL change; data_out is don't-care.
REQ-027 On a miss in IDLE, busy SHALL go 1 from the next cycle until the refill completes; data_out_ready SHALL be 0 throughout.
REQ-028 States: IDLE, WB, RD_CMD, RD, with the transitions given in REQ-029 to REQ-031.
REQ-029 Miss with a valid, dirty victim: IDLE→WB; br_cmd=1, br_cmd_en=1 for exactly the first WB cycle, br_addr = ({victim tag, index, 5'b0} >> RAM_ADDRESSING_MODE) truncated to RAM_DEPTH_BITWIDTH; br_wr_data = beats 0..3 on 4 consecutive cycles starting with the command cycle; then →RD_CMD.
REQ-030 Miss with a clean or invalid victim: IDLE→RD_CMD directly.
REQ-031 RD_CMD: br_cmd=0, br_cmd_en=1 for one cycle with br_addr of the requested line, then →RD; each br_rd_data_valid beat fills the next 64 bits; after the 4th beat the line is marked valid and clean, tag is stored, and the FSM goes →IDLE with busy=0.
REQ-032 The beat after refill SHALL then serve the request as a hit (a write-miss is write-allocate: the write is applied via the hit path).
REQ-033 The requester SHALL hold enable, address, data_in and write_enable stable until data_out_ready=1; a change during busy is ignored until IDLE.
REQ-034 br_cmd_en SHALL be 0 in all cycles other than those in REQ-029 and REQ-031; br_rd_data_valid outside RD SHALL be ignored.
REQ-035 Upper address bits beyond the RAM span SHALL wrap through the truncation of br_addr.

Reset
REQ-036 While rst_n=1: all valid and dirty bits SHALL clear, state SHALL be IDLE, and busy=0, br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0; data_out_ready=0 unless a hit (impossible after reset).
REQ-037 Reset mid-burst SHALL abort the burst immediately, and line contents SHALL be discarded.

Verification
REQ-038 Read 0x0000_0000 after reset -> busy=1, RD_CMD br_cmd_en=1 br_cmd=0 br_addr=0; supply beats 0x1111_1111_0000_0000, …; then data_out=0x0000_0000 with data_out_ready=1; address 0x4 -> 0x1111_1111 same cycle.
REQ-039 Write 0xDEADBEEF, strobe 4'b0001 to 0x0 (hit) -> next read of 0x0 returns 0x000000EF; no br_cmd_en.
REQ-040 Read 0x0000_0040 (same index, different tag, LINE_IX_BITWIDTH=1) -> write-back burst br_cmd=1 br_addr=0 with beat0 low word 0x000000EF, then read burst br_addr=8, then data.
REQ-041 Clean-line conflict miss -> no write burst, only a read command.
REQ-042 Reset asserted during the RD beats -> next cycle busy=0, br_cmd_en=0, and a subsequent read of the same address misses again.
REQ-043 enable=0 with a random address -> data_out_ready=0 and no burst is issued.

Source files
------------

// File: rtl/cache.sv
// ============================================================================
// cache : direct-mapped write-back cache, 32-byte lines refilled over a 4x64 burst
// rev 1.0
// ============================================================================
`default_nettype none

module cache #(
    parameter int LINE_IX_BITWIDTH    = 1,
    parameter int RAM_DEPTH_BITWIDTH  = 10,
    parameter int RAM_ADDRESSING_MODE = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [31:0]                   address,
    input  logic [31:0]                   data_in,
    input  logic [3:0]                    write_enable,
    output logic [31:0]                   data_out,
    output logic                          data_out_ready,
    output logic                          busy,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                   br_wr_data,
    output logic [7:0]                    br_data_mask,
    input  logic [63:0]                   br_rd_data,
    input  logic                          br_rd_data_valid
);

    localparam int c_LINES = 1 << LINE_IX_BITWIDTH;
    localparam int c_TAG_W = 27 - LINE_IX_BITWIDTH;
    localparam int c_MIX_W = LINE_IX_BITWIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_RD_CMD = 2'd2,
        S_RD     = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [1:0]                   r_beat;
    logic [26:0]                  r_req_line;
    logic [c_LINES-1:0]           r_valid;
    logic [c_LINES-1:0]           r_dirty;
    logic [c_TAG_W-1:0]           r_tag [c_LINES];
    logic [31:0]                  r_mem [c_LINES*8];

    logic [26:0]                  w_line_addr;
    logic [LINE_IX_BITWIDTH-1:0]  w_idx;
    logic [c_TAG_W-1:0]           w_tag;
    logic                         w_hit;
    logic [31:0]                  w_victim_byte;
    logic [31:0]                  w_req_byte;
    logic [c_MIX_W-1:0]           w_beat_lo;
    logic [c_MIX_W-1:0]           w_beat_hi;

    // Once a miss is taken the latched request drives the line, so requester
    // changes while busy cannot redirect the burst.
    assign w_line_addr   = (r_state == S_IDLE) ? address[31:5] : r_req_line;
    assign w_idx         = w_line_addr[LINE_IX_BITWIDTH-1:0];
    assign w_tag         = w_line_addr[26:LINE_IX_BITWIDTH];
    assign w_hit         = enable && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_byte = {r_tag[w_idx], w_idx, 5'b0};
    assign w_req_byte    = {w_line_addr, 5'b0};
    assign w_beat_lo     = {w_idx, r_beat, 1'b0};
    assign w_beat_hi     = {w_idx, r_beat, 1'b1};

    assign data_out      = r_mem[{w_idx, address[4:2]}];
    assign br_data_mask  = 8'h00;

    always_comb begin
        w_next         = r_state;
        data_out_ready = 1'b0;
        busy           = 1'b0;
        br_cmd         = 1'b0;
        br_cmd_en      = 1'b0;
        br_addr        = '0;
        br_wr_data     = '0;
        if (!rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        data_out_ready = 1'b1;
                    end else if (enable) begin
                        w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_RD_CMD;
                    end
                end
                S_WB: begin
                    busy       = 1'b1;
                    br_cmd     = 1'b1;
                    br_wr_data = {r_mem[w_beat_hi], r_mem[w_beat_lo]};
                    if (r_beat == 2'd0) begin
                        br_cmd_en = 1'b1;
                        br_addr   = RAM_DEPTH_BITWIDTH'(w_victim_byte >> RAM_ADDRESSING_MODE);
                    end
                    if (r_beat == 2'd3) begin
                        w_next = S_RD_CMD;
                    end
                end
                S_RD_CMD: begin
                    busy      = 1'b1;
                    br_cmd_en = 1'b1;
                    br_addr   = RAM_DEPTH_BITWIDTH'(w_req_byte >> RAM_ADDRESSING_MODE);
                    w_next    = S_RD;
                end
                default: begin
                    busy = 1'b1;
                    if (br_rd_data_valid && (r_beat == 2'd3)) begin
                        w_next = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_beat     <= 2'd0;
            r_req_line <= '0;
            r_valid    <= '0;
            r_dirty    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_beat <= 2'd0;
                    if (enable && !w_hit) begin
                        r_req_line <= address[31:5];
                    end
                    if (w_hit && (write_enable != 4'b0000)) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                S_WB: begin
                    r_beat <= r_beat + 2'd1;
                end
                S_RD_CMD: begin
                    r_beat <= 2'd0;
                end
                default: begin
                    if (br_rd_data_valid) begin
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd3) begin
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Line data and tags carry no reset; the valid bits alone discard them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if ((r_state == S_IDLE) && w_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (write_enable[b]) begin
                        r_mem[{w_idx, address[4:2]}][8*b +: 8] <= data_in[8*b +: 8];
                    end
                end
            end
            if ((r_state == S_RD) && br_rd_data_valid) begin
                r_mem[w_beat_lo] <= br_rd_data[31:0];
                r_mem[w_beat_hi] <= br_rd_data[63:32];
                if (r_beat == 2'd3) begin
                    r_tag[w_idx] <= w_tag;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache.sv
// ============================================================================
// tb_cache : directed self-checking bench for the direct-mapped cache
// rev 1.0
// ============================================================================
`default_nettype none

module tb_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_enable;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [9:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;

    int n_cmp = 0;
    int n_mis = 0;

    cache #(
        .LINE_IX_BITWIDTH   (1),
        .RAM_DEPTH_BITWIDTH (10),
        .RAM_ADDRESSING_MODE(3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .address         (address),
        .data_in         (data_in),
        .write_enable    (write_enable),
        .data_out        (data_out),
        .data_out_ready  (data_out_ready),
        .busy            (busy),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Four read beats; line word j carries base + j*step.
    task automatic feed(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            br_rd_data_valid = 1'b1;
            br_rd_data = {base + step * 32'(2*k+1), base + step * 32'(2*k)};
            #1;
            chk("rd_busy", 64'(busy), 64'd1);
            chk("rd_no_cmd", 64'(br_cmd_en), 64'd0);
        end
        @(negedge clk);
        br_rd_data_valid = 1'b0;
        br_rd_data = '0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; enable = 1'b0; address = '0; data_in = '0;
        write_enable = 4'b0; br_rd_data = '0; br_rd_data_valid = 1'b0;

        // reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_en", 64'(br_cmd_en), 64'd0);
        chk("rst_cmd", 64'(br_cmd), 64'd0);
        chk("rst_addr", 64'(br_addr), 64'd0);
        chk("rst_wr_data", br_wr_data, 64'd0);
        chk("rst_ready", 64'(data_out_ready), 64'd0);
        chk("mask", 64'(br_data_mask), 64'd0);

        // cold read miss of 0x0
        @(negedge clk); rst_n = 1'b0; enable = 1'b1; address = 32'h0; #1;
        chk("miss0_ready", 64'(data_out_ready), 64'd0);
        chk("miss0_busy_idle", 64'(busy), 64'd0);
        @(negedge clk); #1;
        chk("miss0_busy", 64'(busy), 64'd1);
        chk("miss0_cmd_en", 64'(br_cmd_en), 64'd1);
        chk("miss0_cmd", 64'(br_cmd), 64'd0);
        chk("miss0_addr", 64'(br_addr), 64'd0);
        br_rd_data_valid = 1'b1; br_rd_data = 64'hBADB_ADBA_DBAD_BADB;
        feed(32'h0, 32'h1111_1111);
        chk("fill0_busy", 64'(busy), 64'd0);
        chk("fill0_ready", 64'(data_out_ready), 64'd1);
        chk("fill0_w0", 64'(data_out), 64'h0000_0000);
        address = 32'h4; #1;
        chk("fill0_w1", 64'(data_out), 64'h1111_1111);
        chk("fill0_w1_ready", 64'(data_out_ready), 64'd1);
        address = 32'h1C; #1;
        chk("fill0_w7", 64'(data_out), 64'h7777_7777);

        // write hits
        @(negedge clk); address = 32'h0; data_in = 32'hDEAD_BEEF; write_enable = 4'b0001; #1;
        chk("wr0_ready", 64'(data_out_ready), 64'd1);
        chk("wr0_prewrite", 64'(data_out), 64'h0000_0000);
        chk("wr0_no_cmd", 64'(br_cmd_en), 64'd0);
        @(negedge clk); address = 32'h8; data_in = 32'hCAFE_0000; write_enable = 4'b1100; #1;
        chk("wr8_prewrite", 64'(data_out), 64'h2222_2222);
        @(negedge clk); address = 32'h0; write_enable = 4'b0000; #1;
        chk("rd0_after_wr", 64'(data_out), 64'h0000_00EF);
        chk("rd0_no_cmd", 64'(br_cmd_en), 64'd0);
        address = 32'h8; #1;
        chk("rd8_after_wr", 64'(data_out), 64'hCAFE_2222);

        // dirty conflict miss: write-back then refill
        @(negedge clk); address = 32'h40; #1;
        chk("wb_ready", 64'(data_out_ready), 64'd0);
        @(negedge clk); #1;
        chk("wb_busy", 64'(busy), 64'd1);
        chk("wb_cmd_en", 64'(br_cmd_en), 64'd1);
        chk("wb_cmd", 64'(br_cmd), 64'd1);
        chk("wb_addr", 64'(br_addr), 64'd0);
        chk("wb_beat0", br_wr_data, 64'h1111_1111_0000_00EF);
        @(negedge clk); #1;
        chk("wb_cmd_en1", 64'(br_cmd_en), 64'd0);
        chk("wb_beat1", br_wr_data, 64'h3333_3333_CAFE_2222);
        @(negedge clk); #1;
        chk("wb_beat2", br_wr_data, 64'h5555_5555_4444_4444);
        @(negedge clk); #1;
        chk("wb_beat3", br_wr_data, 64'h7777_7777_6666_6666);
        @(negedge clk); #1;
        chk("wb_rdcmd_en", 64'(br_cmd_en), 64'd1);
        chk("wb_rdcmd", 64'(br_cmd), 64'd0);
        chk("wb_rdcmd_addr", 64'(br_addr), 64'd8);
        br_rd_data_valid = 1'b1; br_rd_data = 64'hBADB_ADBA_DBAD_BADB;
        feed(32'hA000_0000, 32'h1);
        chk("fill40_ready", 64'(data_out_ready), 64'd1);
        chk("fill40_w0", 64'(data_out), 64'hA000_0000);
        address = 32'h54; #1;
        chk("fill40_w5", 64'(data_out), 64'hA000_0005);

        // clean conflict miss, then reset during the read beats
        @(negedge clk); address = 32'h0; #1;
        chk("clean_ready", 64'(data_out_ready), 64'd0);
        @(negedge clk); #1;
        chk("clean_cmd_en", 64'(br_cmd_en), 64'd1);
        chk("clean_cmd", 64'(br_cmd), 64'd0);
        chk("clean_addr", 64'(br_addr), 64'd0);
        @(negedge clk); br_rd_data_valid = 1'b1; br_rd_data = 64'hB000_0001_B000_0000;
        @(negedge clk); br_rd_data = 64'hB000_0003_B000_0002;
        @(negedge clk); br_rd_data_valid = 1'b0; br_rd_data = '0; rst_n = 1'b1;
        @(negedge clk); rst_n = 1'b0; enable = 1'b0; #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cmd_en", 64'(br_cmd_en), 64'd0);
        @(negedge clk); enable = 1'b1; address = 32'h0; #1;
        chk("abort_remiss", 64'(data_out_ready), 64'd0);
        @(negedge clk); #1;
        chk("abort_cmd_en2", 64'(br_cmd_en), 64'd1);
        chk("abort_cmd2", 64'(br_cmd), 64'd0);
        feed(32'hC000_0000, 32'h1);
        chk("abort_fill_w0", 64'(data_out), 64'hC000_0000);
        chk("abort_fill_ready", 64'(data_out_ready), 64'd1);

        // upper bits wrap through br_addr truncation, line index 1
        @(negedge clk); address = 32'h0000_2020; #1;
        chk("wrap_ready", 64'(data_out_ready), 64'd0);
        @(negedge clk); #1;
        chk("wrap_cmd_en", 64'(br_cmd_en), 64'd1);
        chk("wrap_addr", 64'(br_addr), 64'h004);
        feed(32'hD000_0000, 32'h1);
        address = 32'h0000_2024; #1;
        chk("wrap_w1", 64'(data_out), 64'hD000_0001);
        chk("line0_kept_ready", 64'(data_out_ready), 64'd1);
        address = 32'h0000_0020; #1;
        chk("wrap_alias_miss", 64'(data_out_ready), 64'd0);
        enable = 1'b0; #1;

        // idle requester
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); enable = 1'b0; address = $urandom; #1;
            chk("noen_ready", 64'(data_out_ready), 64'd0);
            chk("noen_cmd_en", 64'(br_cmd_en), 64'd0);
            chk("noen_busy", 64'(busy), 64'd0);
        end
        @(negedge clk); enable = 1'b1; address = 32'h0000_2024; #1;
        chk("noen_hit_kept", 64'(data_out), 64'hD000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
